msx_bus_cycle: RTL and testbench

Decodes filtered MSX cartridge bus control lines into single-clock memory/IO read and write strobes for the internal register and memory logic. Sits directly downstream of the GPIO pin filters: it consumes their stabilized /SLTSL, /MREQ, /IORQ, /RD and /WR outputs, qualifies a bus cycle and latches address and write data. It also drives the data-bus output enable for read cycles. A watchdog aborts cycles whose strobe never releases.

---
 rtl/msx_bus_cycle.sv | 179 +++++++++++++++++
 tb/tb_msx_bus_cycle.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msx_bus_cycle.sv
// MSX cartridge bus cycle decoder: qualifies filtered /SLTSL,/MREQ,/IORQ,/RD,/WR
// into single-clock memory/IO strobes, latches address/data and drives data_oe.
module msx_bus_cycle #(
  parameter int unsigned QUAL_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ena,
  input  logic        sltsl_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  output logic [15:0] cyc_addr,
  output logic [7:0]  cyc_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        io_rd,
  output logic        io_wr,
  output logic        data_oe,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUAL   = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  localparam logic [2:0] QUAL_N  = 3'(QUAL_CYCLES);
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  // Decode, {space, dir}: space 1 = IO, dir 1 = write
  logic       dec_mem, dec_io, dec_rd, dec_wr, dec_valid;
  logic [1:0] dec;

  always_comb begin
    dec_mem   = ~sltsl_n & ~mreq_n & iorq_n;
    dec_io    = ~iorq_n & mreq_n;
    dec_rd    = ~rd_n & wr_n;
    dec_wr    = ~wr_n & rd_n;
    dec_valid = (dec_mem ^ dec_io) & (dec_rd ^ dec_wr);
    dec       = {dec_io, dec_wr};
  end

  state_e      state_q, state_d;
  logic [1:0]  dec_q, dec_d;
  logic [2:0]  qual_cnt_q, qual_cnt_d;
  logic [7:0]  wd_cnt_q, wd_cnt_d;
  logic [15:0] cyc_addr_q, cyc_addr_d;
  logic [7:0]  cyc_wdata_q, cyc_wdata_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic        io_rd_q, io_rd_d;
  logic        io_wr_q, io_wr_d;
  logic        data_oe_q, data_oe_d;
  logic        busy_q, busy_d;
  logic        timeout_q, timeout_d;
  logic        accept;
  logic        released;

  always_comb begin
    state_d     = state_q;
    dec_d       = dec_q;
    qual_cnt_d  = qual_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    cyc_addr_d  = cyc_addr_q;
    cyc_wdata_d = cyc_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    io_rd_d     = 1'b0;
    io_wr_d     = 1'b0;
    timeout_d   = 1'b0;
    data_oe_d   = data_oe_q;
    accept      = 1'b0;
    released    = ena & rd_n & wr_n;

    unique case (state_q)
      IDLE: begin
        if (ena && dec_valid) begin
          dec_d      = dec;
          qual_cnt_d = 3'd1;
          if (QUAL_N == 3'd1) accept = 1'b1;
          else                state_d = QUAL;
        end
      end
      QUAL: begin
        if (ena) begin
          if (dec_valid && dec == dec_q) begin
            if (qual_cnt_q + 3'd1 == QUAL_N) accept = 1'b1;
            else                             qual_cnt_d = qual_cnt_q + 3'd1;
          end else begin
            state_d    = IDLE;
            qual_cnt_d = 3'd0;
          end
        end
      end
      ACTIVE: begin
        wd_cnt_d = (wd_cnt_q == 8'hFF) ? wd_cnt_q : wd_cnt_q + 8'd1;
        // Release has priority over a watchdog expiring on the same edge
        if (released) begin
          state_d   = IDLE;
          data_oe_d = 1'b0;
        end else if (wd_cnt_q == WD_LAST) begin
          state_d   = DRAIN;
          timeout_d = 1'b1;
          data_oe_d = 1'b0;
        end
      end
      DRAIN: begin
        if (released) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d     = ACTIVE;
      qual_cnt_d  = 3'd0;
      wd_cnt_d    = '0;
      cyc_addr_d  = addr;
      cyc_wdata_d = din;
      mem_rd_d    = (dec == 2'b00);
      mem_wr_d    = (dec == 2'b01);
      io_rd_d     = (dec == 2'b10);
      io_wr_d     = (dec == 2'b11);
      data_oe_d   = ~dec[0];
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      dec_q       <= '0;
      qual_cnt_q  <= '0;
      wd_cnt_q    <= '0;
      cyc_addr_q  <= '0;
      cyc_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      io_rd_q     <= 1'b0;
      io_wr_q     <= 1'b0;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dec_q       <= dec_d;
      qual_cnt_q  <= qual_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      cyc_addr_q  <= cyc_addr_d;
      cyc_wdata_q <= cyc_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      io_rd_q     <= io_rd_d;
      io_wr_q     <= io_wr_d;
      data_oe_q   <= data_oe_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign cyc_addr  = cyc_addr_q;
  assign cyc_wdata = cyc_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign io_rd     = io_rd_q;
  assign io_wr     = io_wr_q;
  assign data_oe   = data_oe_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_msx_bus_cycle.sv
// Bench for msx_bus_cycle: cycle-by-cycle comparison against a behavioural
// bus-cycle model plus directed literal checks.
module tb_msx_bus_cycle;
  localparam int unsigned QC = 2;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset_n, ena;
  logic        sltsl_n, mreq_n, iorq_n, rd_n, wr_n;
  logic [15:0] addr;
  logic [7:0]  din;
  logic [15:0] cyc_addr;
  logic [7:0]  cyc_wdata;
  logic        mem_rd, mem_wr, io_rd, io_wr, data_oe, busy, timeout;

  always #5 clk = ~clk;

  msx_bus_cycle #(.QUAL_CYCLES(QC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena),
    .sltsl_n(sltsl_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .din(din),
    .cyc_addr(cyc_addr), .cyc_wdata(cyc_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .io_rd(io_rd), .io_wr(io_wr),
    .data_oe(data_oe), .busy(busy), .timeout(timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Behavioural model: kind 0 none, 1 mem rd, 2 mem wr, 3 io rd, 4 io wr
  int          run = 0, run_kind = 0, age = 0;
  bit          in_cyc = 0, draining = 0;
  logic [15:0] e_addr = '0;
  logic [7:0]  e_wdata = '0;
  bit          e_mem_rd = 0, e_mem_wr = 0, e_io_rd = 0, e_io_wr = 0;
  bit          e_oe = 0, e_busy = 0, e_to = 0;

  function automatic int bus_kind(input logic s, m, i, r, w);
    bit is_mem, is_io, is_rd, is_wr;
    is_mem = !s && !m && i;
    is_io  = !i && m;
    is_rd  = !r && w;
    is_wr  = !w && r;
    if (is_mem == is_io || is_rd == is_wr) return 0;
    return (is_io ? 3 : 1) + (is_wr ? 1 : 0);
  endfunction

  task automatic model_step();
    int k;
    if (!reset_n) begin
      run = 0; run_kind = 0; age = 0; in_cyc = 0; draining = 0;
      e_addr = '0; e_wdata = '0;
      {e_mem_rd, e_mem_wr, e_io_rd, e_io_wr, e_oe, e_busy, e_to} = '0;
      return;
    end
    k = bus_kind(sltsl_n, mreq_n, iorq_n, rd_n, wr_n);
    {e_mem_rd, e_mem_wr, e_io_rd, e_io_wr, e_to} = '0;
    if (in_cyc) begin
      if (ena && rd_n && wr_n) begin
        in_cyc = 0; draining = 0; e_oe = 0;
      end else if (!draining && age == int'(TO) - 1) begin
        draining = 1; e_to = 1; e_oe = 0;
      end
      if (age < 255) age++;
    end else if (ena) begin
      if (k != 0 && (run == 0 || k == run_kind)) begin
        run++;
        run_kind = k;
        if (run == int'(QC)) begin
          in_cyc = 1; run = 0; age = 0;
          e_addr = addr; e_wdata = din;
          e_mem_rd = (k == 1); e_mem_wr = (k == 2);
          e_io_rd  = (k == 3); e_io_wr  = (k == 4);
          e_oe = (k == 1 || k == 3);
        end
      end else begin
        run = 0;
      end
    end
    e_busy = in_cyc || run > 0;
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    checks++;
    if ({cyc_addr, cyc_wdata, mem_rd, mem_wr, io_rd, io_wr, data_oe, busy, timeout} !==
        {e_addr, e_wdata, e_mem_rd, e_mem_wr, e_io_rd, e_io_wr, e_oe, e_busy, e_to}) begin
      errors++;
      $display("FAIL model_cmp t=%0t got addr=%h wd=%h mr=%b mw=%b ir=%b iw=%b oe=%b busy=%b to=%b expected addr=%h wd=%h mr=%b mw=%b ir=%b iw=%b oe=%b busy=%b to=%b",
               $time, cyc_addr, cyc_wdata, mem_rd, mem_wr, io_rd, io_wr, data_oe, busy, timeout,
               e_addr, e_wdata, e_mem_rd, e_mem_wr, e_io_rd, e_io_wr, e_oe, e_busy, e_to);
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout time budget expired");
    $fatal(1);
  end

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic bus_idle();
    sltsl_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  initial begin
    int strobe_at, to_at, n_strobe, n_to;
    reset_n = 1'b0; ena = 1'b1; addr = '0; din = '0;
    bus_idle();
    next_cyc(); next_cyc();
    chk("rst_busy", busy, 0);
    chk("rst_addr", cyc_addr, 16'h0000);
    chk("rst_oe", data_oe, 0);
    reset_n = 1'b1;
    next_cyc();

    // Memory read held 6 clocks
    sltsl_n = 0; mreq_n = 0; rd_n = 0; addr = 16'h4000; din = 8'h11;
    next_cyc();
    chk("t1_qual_strobe", mem_rd, 0);
    chk("t1_qual_busy", busy, 1);
    next_cyc();
    chk("t1_mem_rd", mem_rd, 1);
    chk("t1_addr", cyc_addr, 16'h4000);
    chk("t1_oe", data_oe, 1);
    next_cyc();
    chk("t1_mem_rd_clear", mem_rd, 0);
    chk("t1_oe_hold", data_oe, 1);
    repeat (3) next_cyc();
    chk("t1_oe_late", data_oe, 1);
    bus_idle();
    next_cyc();
    chk("t1_oe_release", data_oe, 0);
    chk("t1_busy_release", busy, 0);
    next_cyc();

    // IO write glitch of a single sample
    iorq_n = 0; wr_n = 0; addr = 16'h0098;
    next_cyc();
    chk("t2_busy_qual", busy, 1);
    bus_idle();
    next_cyc();
    chk("t2_busy_idle", busy, 0);
    chk("t2_no_io_wr", io_wr, 0);
    next_cyc();

    // IO write accept
    iorq_n = 0; wr_n = 0; addr = 16'h0098; din = 8'h5A;
    next_cyc(); next_cyc();
    chk("t3_io_wr", io_wr, 1);
    chk("t3_addr", cyc_addr, 16'h0098);
    chk("t3_wdata", cyc_wdata, 8'h5A);
    chk("t3_oe", data_oe, 0);
    next_cyc();
    chk("t3_io_wr_clear", io_wr, 0);
    bus_idle();
    next_cyc();
    chk("t3_busy_idle", busy, 0);

    // rd_n and wr_n both low: never a decode
    sltsl_n = 0; mreq_n = 0; rd_n = 0; wr_n = 0; addr = 16'h5555;
    repeat (4) begin
      next_cyc();
      chk("t4_busy", busy, 0);
    end
    bus_idle();
    next_cyc();

    // Decode changes mid-qualification
    sltsl_n = 0; mreq_n = 0; rd_n = 0; addr = 16'h1111;
    next_cyc();
    sltsl_n = 1; mreq_n = 1; iorq_n = 0; addr = 16'h00A0;
    next_cyc();
    chk("t5_busy_drop", busy, 0);
    next_cyc();
    chk("t5_busy_requal", busy, 1);
    chk("t5_no_io_rd", io_rd, 0);
    next_cyc();
    chk("t5_io_rd", io_rd, 1);
    chk("t5_addr", cyc_addr, 16'h00A0);
    bus_idle();
    next_cyc();

    // Watchdog: read strobe held 20 clocks
    sltsl_n = 0; mreq_n = 0; rd_n = 0; addr = 16'h8000;
    strobe_at = -1; to_at = -1; n_strobe = 0; n_to = 0;
    for (int i = 1; i <= 20; i++) begin
      next_cyc();
      if (mem_rd)  begin n_strobe++; strobe_at = i; end
      if (timeout) begin n_to++; to_at = i; end
    end
    chk("t6_strobe_count", n_strobe, 1);
    chk("t6_strobe_at", strobe_at, 2);
    chk("t6_timeout_count", n_to, 1);
    chk("t6_timeout_delay", to_at - strobe_at, 8);
    chk("t6_oe", data_oe, 0);
    chk("t6_busy_drain", busy, 1);
    bus_idle();
    next_cyc();
    chk("t6_busy_idle", busy, 0);
    next_cyc();

    // Memory write with ena on every other clock
    sltsl_n = 0; mreq_n = 0; wr_n = 0; addr = 16'hC000; din = 8'hA5;
    n_strobe = 0; strobe_at = -1;
    for (int i = 0; i < 8; i++) begin
      ena = (i % 2 == 0);
      next_cyc();
      if (mem_wr) begin n_strobe++; strobe_at = i; end
    end
    chk("t7_wr_count", n_strobe, 1);
    chk("t7_wr_at", strobe_at, 2);
    chk("t7_wdata", cyc_wdata, 8'hA5);
    bus_idle();
    ena = 0;
    next_cyc();
    chk("t7_busy_no_ena", busy, 1);
    ena = 1;
    next_cyc();
    chk("t7_busy_idle", busy, 0);

    // Async reset during an active read
    sltsl_n = 0; mreq_n = 0; rd_n = 0; addr = 16'h1234;
    next_cyc(); next_cyc();
    chk("t8_oe_active", data_oe, 1);
    #1 reset_n = 0;
    #1;
    chk("t8_oe_async", data_oe, 0);
    chk("t8_busy_async", busy, 0);
    chk("t8_addr_async", cyc_addr, 16'h0000);
    next_cyc();
    bus_idle();
    reset_n = 1;
    next_cyc();
    iorq_n = 0; rd_n = 0; addr = 16'h2222;
    next_cyc(); next_cyc();
    chk("t8_io_rd_after", io_rd, 1);
    chk("t8_addr_after", cyc_addr, 16'h2222);
    chk("t8_oe_after", data_oe, 1);
    bus_idle();
    next_cyc(); next_cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
